// File: rtl/abh_seg.sv
// abh_seg: parametrised address-bus segment (next-address adder, AB/PC registers, deferred-carry fixup).
// Optional macro ABH_SEG_HOLD_EN adds an RDY input that freezes the segment when low.
`default_nettype none

module abh_seg #(
  parameter int unsigned    W        = 8,
  parameter logic [W-1:0]   RESET_AB = {W{1'b1}},
  parameter logic [W-1:0]   RESET_PC = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         RST_N,
  input  logic         CI,
  input  logic [W-1:0] DB,
  input  logic [3:0]   op,
  input  logic         ld_pc,
  input  logic         inc_pc,
  input  logic         fix_en,
`ifdef ABH_SEG_HOLD_EN
  input  logic         RDY,
`endif
  output logic [W-1:0] AD,
  output logic [W-1:0] AB,
  output logic [W-1:0] PC,
  output logic         CO,
  output logic         fixup
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FIX  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] ab_q, ab_d;
  logic [W-1:0] pc_q, pc_d;

  logic         adv;
  logic         defer;
  logic [W-1:0] base;
  logic [W-1:0] add_a, add_b;
  logic         add_c;
  logic [W:0]   sum;

`ifdef ABH_SEG_HOLD_EN
  assign adv = RDY;
`else
  assign adv = 1'b1;
`endif

  assign defer = (op[1:0] == 2'b10) && fix_en;

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ab_q    <= RESET_AB;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        S_IDLE:  if (defer && CI) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // One shared adder: every addend case reduces to a + b + c with a W+1 bit carry.
  always_comb begin
    case (op[3:2])
      2'b00:   base = '0;
      2'b01:   base = ab_q;
      2'b10:   base = pc_q;
      default: base = DB;
    endcase

    add_a = base;
    add_b = '0;
    add_c = 1'b0;
    if (!adv) begin
      add_a = ab_q;
    end else if (state_q == S_FIX) begin
      add_a = ab_q;
      add_c = 1'b1;
    end else if (!defer) begin
      case (op[1:0])
        2'b01:   add_c = 1'b1;
        2'b10:   add_c = CI;
        2'b11: begin
          add_b = {W{1'b1}};
          add_c = CI;
        end
        default: add_c = 1'b0;
      endcase
    end

    sum   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c};
    AD    = sum[W-1:0];
    CO    = sum[W];
    fixup = (state_q == S_FIX);
  end

  always_comb begin
    ab_d = adv ? AD : ab_q;
    pc_d = pc_q;
    if (adv && ld_pc) pc_d = ab_q + {{(W-1){1'b0}}, inc_pc};
  end

  assign AB = ab_q;
  assign PC = pc_q;

endmodule

`default_nettype wire

// File: doc/abh_seg.md
Name: abh_seg

Overview:
- Parametrised address-bus segment unit. Successor to the fixed 8-bit ABH calculator.
- Computes the next address-bus segment from a selectable base plus an addend, and registers it.
- Holds the program-counter segment.
- New: carry-out generation and an optional deferred-carry "fixup" state machine that inserts one extra cycle on page crossing.
- Instantiated once per address segment above ABL; ABL's carry feeds CI.

Parameters:
- W, 8: segment width in bits (W >= 2).
- RESET_AB, {W{1'b1}}: AB value after reset.
- RESET_PC, {W{1'b1}}: PC value after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous reset, active-low.
- CI  input  1  carry in from the lower segment.
- DB  input  W  data bus.
- op  input  4  op[3:2] selects the base; op[1:0] selects the addend.
- ld_pc  input  1  load PC.
- inc_pc  input  1  increment during PC load.
- fix_en  input  1  enable deferred-carry mode for op[1:0]=10.
- AD  output  W  unregistered next address.
- AB  output  W  registered address.
- PC  output  W  program counter segment.
- CO  output  1  carry out of the AD adder (unregistered).
- fixup  output  1  high while in state FIX.

Behaviour:
- Base mux, op[3:2]: 00 -> 0; 01 -> AB; 10 -> PC; 11 -> DB.
- Addend, op[1:0], all arithmetic modulo 2^W:
  - 00: base + 0, CO=0.
  - 01: base + 1, CO = (base == all-ones).
  - 10: base + CI, CO = CI & (base == all-ones).
  - 11: base + {W{1}} + CI, i.e. base-1+CI. CO = (base != 0) | CI.
- States: IDLE, FIX. Reset enters IDLE.
- IDLE, deferred case: op[1:0]==10 and fix_en==1.
  - AD = base, CO=0.
  - If CI==1, next state is FIX; if CI==0, stay in IDLE.
- IDLE, all other cases: AD per the table above; stay in IDLE.
- FIX:
  - op, CI, fix_en and DB are ignored.
  - AD = AB + 1; CO = (AB == all-ones).
  - fixup = 1.
  - Next state is always IDLE.
- fixup = 1 only in FIX, so it is high for exactly one cycle per deferred carry.
- AB <= AD every cycle (no enable).
- PC: if ld_pc, PC <= AB + inc_pc, using the registered AB value. Honoured in both states. Wraps from all-ones+1 to 0. When ld_pc=0, PC holds.
- Reset (RST_N==0 at a clock edge):
  - AB <= RESET_AB; PC <= RESET_PC; state <= IDLE.
  - The reset overrides ld_pc and any pending FIX.
  - fixup reads 0 from the cycle after the reset edge.
  - AD and CO remain combinational functions of current inputs and state.
- Reset mid-FIX: the fixup increment is discarded; AB takes RESET_AB.
- No reset-to-output combinational path other than through the registers.

Optional Feature:
- Macro: ABH_SEG_HOLD_EN.
- Defined:
  - Adds port RDY, input, 1 bit.
  - When RDY==0: AB, PC and state hold; AD = AB; CO=0; fixup keeps its value.
  - RST_N still takes priority over RDY.
  - When RDY==1: behaviour as specified above.
- Not defined: no RDY port; the block advances every cycle.

Test Plan:
- Reset, W=8: hold RST_N=0 for 2 cycles, then release -> AB=FF, PC=FF, fixup=0. While ld_pc=1 during reset, PC stays FF.
- Adder table, W=8: base DB=7F.
  - op=1101 -> AD=80, CO=0.
  - DB=FF with op=1101 -> AD=00, CO=1.
  - DB=00, op=1111, CI=0 -> AD=FF, CO=0.
  - DB=00, op=1111, CI=1 -> AD=00, CO=1.
- Deferred carry: AB=12, op=0110, fix_en=1, CI=1 -> cycle 0 AD=12. Cycle 1 fixup=1, AD=13. Cycle 2 AB=13, fixup=0. With CI=0 -> no FIX cycle.
- PC load: AB=3F, ld_pc=1, inc_pc=1 -> PC=40 next cycle. AB=FF, inc_pc=1 -> PC=00. ld_pc=0 -> PC holds.
- W=16, RESET_AB=0000: DB=FFFF, op=1110, CI=1, fix_en=0 -> AD=0000, CO=1. Next cycle AB=0000.
- Reset mid-FIX, and hold: enter FIX, assert RST_N=0 -> AB=RESET_AB, state IDLE, fixup=0.
  - With ABH_SEG_HOLD_EN: RDY=0 in FIX for 3 cycles -> AB and fixup frozen (AD = AB, CO=0). After RDY=1, AB increments once and fixup drops.
